// File: rtl/fpu_addsub_ctrl.sv
// Sequencer for binary32 add/subtract around the multi-cycle fpu_sumdiff datapath:
// special-case bypass, cs/ready handshake, left normalization after cancellation and packing.
module fpu_addsub_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        op_sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        invalid,
    output logic        overflow,
    output logic        su_cs,
    input  logic        su_ready,
    output logic [47:0] su_x,
    output logic [23:0] su_y,
    output logic [7:0]  su_exp_x,
    output logic [7:0]  su_exp_y,
    output logic        su_sgn_x,
    output logic        su_sgn_y,
    input  logic [47:0] su_r,
    input  logic [7:0]  su_exp_r,
    input  logic        su_sgn_r
);

    typedef enum logic [3:0] {
        SYNC, IDLE, CHECK, START, WAIT, RELEASE, NORM, PACK, DONE
    } state_t;

    state_t      state_reg;
    logic [2:0]  cnt_reg;
    logic        from_sync_reg;

    logic        a_sgn_reg, b_sgn_reg;
    logic [30:0] a_mag_reg, b_mag_reg;

    logic        byp_reg;
    logic [31:0] byp_val_reg;
    logic        byp_inv_reg;

    logic [24:0] r_reg;
    logic [7:0]  e_reg;
    logic        s_reg;
    logic        ovf_pend_reg;

    logic        busy_reg, done_reg, invalid_reg, overflow_reg, su_cs_reg;
    logic [31:0] result_reg;

    // Only the low 25 bits of the datapath result carry the normalized mantissa.
    logic        unused_su_r;
    assign unused_su_r = ^su_r[47:25];

    // Operand classification; magnitudes are already flushed to zero for exp==0.
    logic [30:0] op_mag [2];
    logic [1:0]  is_nan, is_inf, is_zero;

    assign op_mag[0] = a_mag_reg;
    assign op_mag[1] = b_mag_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_class
            assign is_nan[gi]  = (op_mag[gi][30:23] == 8'hFF) && (op_mag[gi][22:0] != 23'h0);
            assign is_inf[gi]  = (op_mag[gi][30:23] == 8'hFF) && (op_mag[gi][22:0] == 23'h0);
            assign is_zero[gi] = (op_mag[gi][30:23] == 8'h00);
        end
    endgenerate

    logic        byp_hit;
    logic        byp_inv;
    logic [31:0] byp_val;

    always_comb begin
        byp_hit = 1'b1;
        byp_inv = (|is_nan) || ((&is_inf) && (a_sgn_reg != b_sgn_reg));
        byp_val = 32'h7FC0_0000;
        if (!byp_inv) begin
            if (is_inf[0])
                byp_val = {a_sgn_reg, 8'hFF, 23'h0};
            else if (is_inf[1])
                byp_val = {b_sgn_reg, 8'hFF, 23'h0};
            else if (&is_zero)
                byp_val = {a_sgn_reg & b_sgn_reg, 31'h0};
            else if (is_zero[0])
                byp_val = {b_sgn_reg, b_mag_reg};
            else if (is_zero[1])
                byp_val = {a_sgn_reg, a_mag_reg};
            else begin
                byp_hit = 1'b0;
                byp_val = 32'h0;
            end
        end
    end

    // Datapath operands come straight from the latch, so they cannot move between START and RELEASE.
    assign su_x     = {24'h0, |a_mag_reg[30:23], a_mag_reg[22:0]};
    assign su_y     = {|b_mag_reg[30:23], b_mag_reg[22:0]};
    assign su_exp_x = a_mag_reg[30:23];
    assign su_exp_y = b_mag_reg[30:23];
    assign su_sgn_x = a_sgn_reg;
    assign su_sgn_y = b_sgn_reg;

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign result   = result_reg;
    assign invalid  = invalid_reg;
    assign overflow = overflow_reg;
    assign su_cs    = su_cs_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= SYNC;
            cnt_reg       <= 3'd0;
            from_sync_reg <= 1'b0;
            a_sgn_reg     <= 1'b0;
            b_sgn_reg     <= 1'b0;
            a_mag_reg     <= 31'h0;
            b_mag_reg     <= 31'h0;
            byp_reg       <= 1'b0;
            byp_val_reg   <= 32'h0;
            byp_inv_reg   <= 1'b0;
            r_reg         <= 25'h0;
            e_reg         <= 8'h0;
            s_reg         <= 1'b0;
            ovf_pend_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            result_reg    <= 32'h0;
            invalid_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            su_cs_reg     <= 1'b0;
        end else begin
            case (state_reg)
                // The datapath has no reset: give it time to finish and release it if it does.
                SYNC: begin
                    busy_reg <= 1'b1;
                    if (su_ready) begin
                        state_reg     <= RELEASE;
                        su_cs_reg     <= 1'b1;
                        from_sync_reg <= 1'b1;
                        cnt_reg       <= 3'd0;
                    end else if (cnt_reg == 3'd4) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        cnt_reg   <= 3'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 3'd1;
                    end
                end
                IDLE: begin
                    if (req) begin
                        a_sgn_reg     <= a[31];
                        b_sgn_reg     <= b[31] ^ op_sub;
                        a_mag_reg     <= (a[30:23] == 8'h00) ? 31'h0 : a[30:0];
                        b_mag_reg     <= (b[30:23] == 8'h00) ? 31'h0 : b[30:0];
                        from_sync_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= CHECK;
                    end
                end
                CHECK: begin
                    byp_reg     <= byp_hit;
                    byp_val_reg <= byp_val;
                    byp_inv_reg <= byp_inv;
                    if (byp_hit) begin
                        state_reg <= PACK;
                    end else begin
                        state_reg <= START;
                        su_cs_reg <= 1'b1;
                    end
                end
                START: begin
                    su_cs_reg <= 1'b0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (su_ready) begin
                        r_reg        <= su_r[24:0];
                        e_reg        <= su_exp_r;
                        s_reg        <= su_sgn_r;
                        ovf_pend_reg <= 1'b0;
                        su_cs_reg    <= 1'b1;
                        state_reg    <= RELEASE;
                    end
                end
                RELEASE: begin
                    su_cs_reg <= 1'b0;
                    if (from_sync_reg) begin
                        from_sync_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end else begin
                        state_reg <= NORM;
                    end
                end
                NORM: begin
                    if (r_reg == 25'h0) begin
                        s_reg     <= 1'b0;
                        e_reg     <= 8'h0;
                        state_reg <= PACK;
                    end else if (e_reg == 8'hFF) begin
                        r_reg        <= 25'h0;
                        ovf_pend_reg <= 1'b1;
                        state_reg    <= PACK;
                    end else if (r_reg[23]) begin
                        state_reg <= PACK;
                    end else if (e_reg == 8'h01) begin
                        r_reg     <= 25'h0;
                        e_reg     <= 8'h0;
                        state_reg <= PACK;
                    end else begin
                        r_reg <= r_reg << 1;
                        e_reg <= e_reg - 8'd1;
                    end
                end
                PACK: begin
                    if (byp_reg) begin
                        result_reg   <= byp_val_reg;
                        invalid_reg  <= byp_inv_reg;
                        overflow_reg <= 1'b0;
                    end else begin
                        result_reg   <= {s_reg, e_reg, r_reg[22:0]};
                        invalid_reg  <= 1'b0;
                        overflow_reg <= ovf_pend_reg;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= SYNC;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_addsub_ctrl.sv
// Bench for fpu_addsub_ctrl: behavioural fpu_sumdiff stand-in, arithmetic reference model,
// and a per-cycle compare process driven by directed vectors.
module tb_fpu_addsub_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        op_sub = 1'b0;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        busy, done, invalid, overflow, su_cs;
    logic [31:0] result;
    logic [47:0] su_x;
    logic [23:0] su_y;
    logic [7:0]  su_exp_x, su_exp_y;
    logic        su_sgn_x, su_sgn_y;

    logic        dp_ready = 1'b0;
    logic [24:0] dp_r25 = 25'h0;
    logic [7:0]  dp_e = 8'h0;
    logic        dp_s = 1'b0;
    int          dp_st = 0;
    int          dp_cnt = 0;

    fpu_addsub_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .invalid  (invalid),
        .overflow (overflow),
        .su_cs    (su_cs),
        .su_ready (dp_ready),
        .su_x     (su_x),
        .su_y     (su_y),
        .su_exp_x (su_exp_x),
        .su_exp_y (su_exp_y),
        .su_sgn_x (su_sgn_x),
        .su_sgn_y (su_sgn_y),
        .su_r     ({23'h0, dp_r25}),
        .su_exp_r (dp_e),
        .su_sgn_r (dp_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Aligned add/sub with one guard bit, returning {sign, exp, r[24:0]}.
    function automatic logic [33:0] dp_compute(input logic [23:0] mx, input logic [23:0] my,
                                               input logic [7:0] ex, input logic [7:0] ey,
                                               input logic sx, input logic sy);
        longint vb, vs, v;
        int eb, es, d;
        logic sb;
        logic [24:0] r;
        if ({ex, mx} >= {ey, my}) begin
            vb = longint'(mx); vs = longint'(my); eb = int'(ex); es = int'(ey); sb = sx;
        end else begin
            vb = longint'(my); vs = longint'(mx); eb = int'(ey); es = int'(ex); sb = sy;
        end
        d  = eb - es;
        vb = vb * 2;
        vs = (d > 30) ? 64'd0 : ((vs * 2) >> d);
        v  = (sx == sy) ? vb + vs : vb - vs;
        if (v >= (longint'(1) << 25)) begin
            v = v / 2;
            eb++;
        end
        v = v / 2 + (v % 2);
        if (v >= (longint'(1) << 24)) begin
            v = v / 2;
            eb++;
        end
        if (eb > 255) eb = 255;
        r = v[24:0];
        return {(v == 0) ? 1'b0 : sb, eb[7:0], r};
    endfunction

    // Datapath stand-in: busy for a fixed time after cs, holds ready until the releasing cs.
    always @(posedge clk) begin
        case (dp_st)
            0: if (su_cs) begin
                dp_st  <= 1;
                dp_cnt <= 0;
            end
            1: if (dp_cnt == 3) begin
                {dp_s, dp_e, dp_r25} <= dp_compute(su_x[23:0], su_y, su_exp_x, su_exp_y, su_sgn_x, su_sgn_y);
                dp_ready <= 1'b1;
                dp_st    <= 2;
            end else begin
                dp_cnt <= dp_cnt + 1;
            end
            default: if (su_cs) begin
                dp_ready <= 1'b0;
                dp_st    <= 0;
            end
        endcase
    end

    // Reference: special cases by rule, otherwise datapath result then normalized by leading-one count.
    task automatic model(input logic [31:0] ta, input logic [31:0] tb, input logic tsub,
                         output logic [31:0] res, output logic inv, output logic ovf,
                         output int lat, output logic byp);
        logic sa, sb, s;
        int ea, eb, e, msb, need;
        logic [24:0] r, rr;
        logic [7:0] e8;
        logic nan_a, nan_b, inf_a, inf_b, z_a, z_b;
        sa = ta[31]; sb = tb[31] ^ tsub;
        ea = int'(ta[30:23]); eb = int'(tb[30:23]);
        nan_a = (ea == 255) && (ta[22:0] != 0); nan_b = (eb == 255) && (tb[22:0] != 0);
        inf_a = (ea == 255) && (ta[22:0] == 0); inf_b = (eb == 255) && (tb[22:0] == 0);
        z_a = (ea == 0); z_b = (eb == 0);
        inv = 1'b0; ovf = 1'b0; byp = 1'b1; lat = 3; res = 32'h0;
        if (nan_a || nan_b || (inf_a && inf_b && sa != sb)) begin
            res = 32'h7FC0_0000; inv = 1'b1;
        end else if (inf_a) res = {sa, 8'hFF, 23'h0};
        else if (inf_b) res = {sb, 8'hFF, 23'h0};
        else if (z_a && z_b) res = {sa & sb, 31'h0};
        else if (z_a) res = {sb, tb[30:0]};
        else if (z_b) res = {sa, ta[30:0]};
        else begin
            byp = 1'b0;
            {s, e8, r} = dp_compute({1'b1, ta[22:0]}, {1'b1, tb[22:0]}, ta[30:23], tb[30:23], sa, sb);
            e = int'(e8);
            if (r == 0) begin
                res = 32'h0; lat = 11;
            end else if (e == 255) begin
                res = {s, 8'hFF, 23'h0}; ovf = 1'b1; lat = 11;
            end else begin
                msb = 0;
                for (int i = 0; i < 25; i++) if (r[i]) msb = i;
                need = (msb >= 23) ? 0 : 23 - msb;
                if (need <= e - 1) begin
                    rr  = r << need;
                    e   = e - need;
                    res = {s, e[7:0], rr[22:0]};
                    lat = 11 + need;
                end else begin
                    res = {s, 31'h0};
                    lat = 11 + e - 1;
                end
            end
        end
    endtask

    logic        op_active = 1'b0;
    int          t0 = 0;
    int          rel;
    logic [31:0] e_res;
    logic        e_inv, e_ovf, e_byp;
    int          e_lat = 0;
    logic [23:0] e_mx, e_my;
    logic [7:0]  e_ex, e_ey;
    logic        e_sx, e_sy;
    logic        prev_cs = 1'b0;

    assign rel = cyc - t0;

    always @(negedge clk) begin
        if (su_cs) check("su_cs_back_to_back", prev_cs, 0);
        prev_cs <= su_cs;
        if (op_active && rel >= 1 && rel <= e_lat + 1) begin
            check("busy", busy, rel <= e_lat);
            check("done", done, rel == e_lat);
            check("su_cs", su_cs, !e_byp && (rel == 2 || rel == 8));
            if (done) begin
                check("result", result, e_res);
                check("invalid", invalid, e_inv);
                check("overflow", overflow, e_ovf);
            end
            if (!e_byp && rel >= 2 && rel <= 8) begin
                check("su_x", su_x, {24'h0, e_mx});
                check("su_y", su_y, e_my);
                check("su_exp", {su_exp_x, su_exp_y}, {e_ex, e_ey});
                check("su_sgn", {su_sgn_x, su_sgn_y}, {e_sx, e_sy});
            end
        end
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("idle_before_req", busy, 0);
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tsub);
        logic [31:0] r;
        logic i, o, bp;
        int l, k;
        model(ta, tb, tsub, r, i, o, l, bp);
        wait_idle();
        a = ta; b = tb; op_sub = tsub; req = 1'b1;
        e_res = r; e_inv = i; e_ovf = o; e_lat = l; e_byp = bp;
        e_mx = (ta[30:23] == 0) ? 24'h0 : {1'b1, ta[22:0]};
        e_my = (tb[30:23] == 0) ? 24'h0 : {1'b1, tb[22:0]};
        e_ex = ta[30:23]; e_ey = tb[30:23];
        e_sx = ta[31];    e_sy = tb[31] ^ tsub;
        t0 = cyc;
        op_active = 1'b1;
        @(negedge clk);
        req = 1'b0;
        k = 1;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", done, 1);
        check("latency", k, l);
        $display("op %h %s %h -> %h inv=%0b ovf=%0b done after %0d cycles",
                 ta, tsub ? "-" : "+", tb, result, invalid, overflow, k);
        @(negedge clk);
        @(negedge clk);
        op_active = 1'b0;
    endtask

    localparam int NV = 16;
    logic [31:0] va [NV] = '{32'h3F800000, 32'h3FC00000, 32'h40400000, 32'h7F800000,
                             32'h7F7FFFFF, 32'h7F800001, 32'hFF800000, 32'h3F800000,
                             32'h80000000, 32'h00000000, 32'h00000001, 32'h3F800000,
                             32'h00000000, 32'h3FA00000, 32'h00800001, 32'h01000001};
    logic [31:0] vb [NV] = '{32'h3F800000, 32'h3FA00000, 32'h40400000, 32'h7F800000,
                             32'h7F7FFFFF, 32'h3F800000, 32'h3F800000, 32'h7F800000,
                             32'h00000000, 32'h00000000, 32'h3F800000, 32'h00000000,
                             32'h3F800000, 32'h3FC00000, 32'h00800000, 32'h01000000};
    logic        vs [NV] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                             1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    initial begin
        logic [31:0] pr;
        logic pi, po, pb, saw;
        int pl, k, pulses;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_flags", {invalid, overflow}, 0);
        check("rst_su_cs", su_cs, 0);
        check("rst_su_x", su_x, 0);
        check("rst_su_y", su_y, 0);

        // Hand-computed anchors for the reference model.
        model(32'h3F800000, 32'h3F800000, 1'b0, pr, pi, po, pl, pb);
        check("pin_1p1_res", pr, 32'h40000000);
        check("pin_1p1_lat", pl, 11);
        model(32'h3FC00000, 32'h3FA00000, 1'b1, pr, pi, po, pl, pb);
        check("pin_cancel_res", pr, 32'h3E800000);
        check("pin_cancel_lat", pl, 13);
        model(32'h7F800000, 32'h7F800000, 1'b1, pr, pi, po, pl, pb);
        check("pin_infinf_res", {pi, pr}, {1'b1, 32'h7FC00000});
        check("pin_infinf_lat", pl, 3);
        model(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, pr, pi, po, pl, pb);
        check("pin_ovf_res", {po, pr}, {1'b1, 32'h7F800000});

        rst = 1'b0;
        @(negedge clk);
        check("sync_busy", busy, 1);
        k = 1;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("sync_exit", busy, 0);
        check("sync_len", (k - 1 >= 4) && (k - 1 <= 5), 1);
        $display("sync after reset: busy for %0d cycles", k - 1);

        for (int i = 0; i < NV; i++) run_op(va[i], vb[i], vs[i]);

        // Reset in the middle of WAIT: SYNC must release the still-running datapath.
        run_op(32'h7F800000, 32'h7F800000, 1'b1);
        wait_idle();
        a = 32'h3F800000; b = 32'h3F800000; op_sub = 1'b0; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_flags", {invalid, overflow, done}, 0);
        check("midrst_result", result, 0);
        check("midrst_su_cs", su_cs, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0; saw = 1'b0; k = 0;
        while (k < 20) begin
            @(negedge clk);
            k++;
            if (su_cs) pulses++;
            if (busy) saw = 1'b1;
            else if (saw) break;
        end
        check("rst_sync_busy", saw, 1);
        check("rst_release_pulses", pulses, 1);
        check("rst_back_idle", busy, 0);
        $display("mid-op reset: %0d release pulse(s), idle after %0d cycles", pulses, k);

        run_op(32'h3F800000, 32'h40000000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
